// File: rtl/instr_fetch.sv
// Instruction fetch stage: drives the PC, fetches words from imem over req/ack,
// and queues {word, addr} in a small FIFO for decode.
module instr_fetch #(
    parameter int unsigned WORD_SIZE = 32,
    parameter int unsigned DEPTH     = 2
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WORD_SIZE-1:0] pc_cur,
    output logic                 pc_we,
    output logic [WORD_SIZE-1:0] pc_in,
    output logic                 imem_req,
    output logic [WORD_SIZE-1:0] imem_addr,
    input  logic                 imem_ack,
    input  logic [WORD_SIZE-1:0] imem_rdata,
    input  logic                 branch_taken,
    input  logic [WORD_SIZE-1:0] branch_target,
    output logic                 instr_valid,
    output logic [WORD_SIZE-1:0] instr,
    output logic [WORD_SIZE-1:0] instr_pc,
    input  logic                 instr_ready
);

    localparam int unsigned PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        DROP = 2'd2
    } state_e;

    state_e               state_q, state_d;
    logic [WORD_SIZE-1:0] fetch_addr_q, fetch_addr_d;
    logic [WORD_SIZE-1:0] word_q [DEPTH];
    logic [WORD_SIZE-1:0] word_d [DEPTH];
    logic [WORD_SIZE-1:0] addr_q [DEPTH];
    logic [WORD_SIZE-1:0] addr_d [DEPTH];
    logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
    logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
    logic [CNT_W-1:0]     count_q, count_d;
    logic                 req_q, req_d;
    logic                 valid_q, valid_d;
    logic                 full;
    logic                 push;
    logic                 pop;

    assign full = (count_q == CNT_W'(DEPTH));
    assign pop  = !branch_taken && (count_q != '0) && instr_ready;

    // Fetch FSM: a branch never cancels the outstanding request, it only marks it for drop
    always_comb begin
        state_d      = state_q;
        fetch_addr_d = fetch_addr_q;
        push         = 1'b0;
        case (state_q)
            IDLE: begin
                if (!branch_taken && !full) begin
                    fetch_addr_d = pc_cur;
                    state_d      = WAIT;
                end
            end
            WAIT: begin
                if (imem_ack) begin
                    push    = !branch_taken;
                    state_d = IDLE;
                end else if (branch_taken) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (imem_ack) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Instruction FIFO; a branch flushes it and overrides any same-cycle pop
    always_comb begin
        word_d   = word_q;
        addr_d   = addr_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (branch_taken) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) begin
                word_d[wr_ptr_q] = imem_rdata;
                addr_d[wr_ptr_q] = fetch_addr_q;
                wr_ptr_d         = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            count_d = count_q + CNT_W'(push) - CNT_W'(pop);
        end
        req_d   = (state_d != IDLE);
        valid_d = (count_d != '0);
    end

    // PC control: load target on branch, hold while busy or full, else let it auto-increment
    always_comb begin
        pc_we = 1'b0;
        pc_in = '0;
        if (reset) begin
            if (branch_taken) begin
                pc_we = 1'b1;
                pc_in = branch_target;
            end else if ((state_q != IDLE) || full) begin
                pc_we = 1'b1;
                pc_in = pc_cur;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q      <= IDLE;
            fetch_addr_q <= '0;
            word_q       <= '{default: '0};
            addr_q       <= '{default: '0};
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            count_q      <= '0;
            req_q        <= 1'b0;
            valid_q      <= 1'b0;
        end else begin
            state_q      <= state_d;
            fetch_addr_q <= fetch_addr_d;
            word_q       <= word_d;
            addr_q       <= addr_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            count_q      <= count_d;
            req_q        <= req_d;
            valid_q      <= valid_d;
        end
    end

    assign imem_req    = req_q;
    assign imem_addr   = fetch_addr_q;
    assign instr_valid = valid_q;
    assign instr       = valid_q ? word_q[rd_ptr_q] : '0;
    assign instr_pc    = valid_q ? addr_q[rd_ptr_q] : '0;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a PC register model and a variable-latency
// instruction memory model.
module tb_instr_fetch;

    logic        clk;
    logic        reset;
    logic [31:0] pc_cur;
    logic        pc_we;
    logic [31:0] pc_in;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        instr_valid;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        instr_ready;

    int n_vec;
    int n_err;
    int ack_delay;
    int wait_cnt;

    instr_fetch #(.WORD_SIZE(32), .DEPTH(2)) dut (
        .clk           (clk),
        .reset         (reset),
        .pc_cur        (pc_cur),
        .pc_we         (pc_we),
        .pc_in         (pc_in),
        .imem_req      (imem_req),
        .imem_addr     (imem_addr),
        .imem_ack      (imem_ack),
        .imem_rdata    (imem_rdata),
        .branch_taken  (branch_taken),
        .branch_target (branch_target),
        .instr_valid   (instr_valid),
        .instr         (instr),
        .instr_pc      (instr_pc),
        .instr_ready   (instr_ready)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Register-file PC: reset to 0, load pc_in on pc_we, else +4
    always @(posedge clk or negedge reset) begin
        if (!reset)     pc_cur <= 32'h0;
        else if (pc_we) pc_cur <= pc_in;
        else            pc_cur <= pc_cur + 32'd4;
    end

    // Memory: ack after ack_delay wait cycles; word is a tag plus the low address bits
    always @(posedge clk or negedge reset) begin
        if (!reset)                    wait_cnt <= 0;
        else if (imem_req && !imem_ack) wait_cnt <= wait_cnt + 1;
        else                           wait_cnt <= 0;
    end
    assign imem_ack   = imem_req && (wait_cnt >= ack_delay);
    assign imem_rdata = {16'hC0DE, imem_addr[15:0]};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic do_reset(input logic ready, input int delay);
        @(negedge clk);
        reset        = 1'b0;
        branch_taken = 1'b0;
        instr_ready  = ready;
        ack_delay    = delay;
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        n_vec         = 0;
        n_err         = 0;
        reset         = 1'b0;
        branch_taken  = 1'b0;
        branch_target = 32'h0;
        instr_ready   = 1'b1;
        ack_delay     = 0;

        // Reset state
        #2;
        chk("rst_req",   32'(imem_req),    32'h0);
        chk("rst_addr",  imem_addr,        32'h0);
        chk("rst_valid", 32'(instr_valid), 32'h0);
        chk("rst_instr", instr,            32'h0);
        chk("rst_ipc",   instr_pc,         32'h0);
        chk("rst_pcwe",  32'(pc_we),       32'h0);
        chk("rst_pcin",  pc_in,            32'h0);

        // Zero-wait streaming: 0x0, 0x4, 0x8 on alternate cycles
        do_reset(1'b1, 0);
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            chk("s_req",  32'(imem_req), 32'h1);
            chk("s_addr", imem_addr,     32'(4 * k));
            chk("s_pc",   pc_cur,        32'(4 * k + 4));
            @(negedge clk);
            chk("s_req0",  32'(imem_req),    32'h0);
            chk("s_valid", 32'(instr_valid), 32'h1);
            chk("s_ipc",   instr_pc,         32'(4 * k));
            chk("s_instr", instr,            32'hC0DE0000 | 32'(4 * k));
        end

        // Stalled decode: two fetches fill the buffer, then the PC holds at 0x8
        do_reset(1'b0, 0);
        @(negedge clk); chk("f_addr0", imem_addr, 32'h0);
        @(negedge clk); chk("f_v0", 32'(instr_valid), 32'h1);
        @(negedge clk); chk("f_addr1", imem_addr, 32'h4); chk("f_pc1", pc_cur, 32'h8);
        @(negedge clk);
        chk("f_req_full", 32'(imem_req), 32'h0);
        chk("f_pcwe",     32'(pc_we),    32'h1);
        chk("f_head",     instr_pc,      32'h0);
        @(negedge clk); chk("f_hold1", pc_cur, 32'h8); chk("f_idle1", 32'(imem_req), 32'h0);
        @(negedge clk); chk("f_hold2", pc_cur, 32'h8); chk("f_idle2", 32'(imem_req), 32'h0);
        instr_ready = 1'b1;
        @(negedge clk);
        chk("f_head2", instr_pc, 32'h4);
        chk("f_hold3", pc_cur,   32'h8);
        @(negedge clk);
        chk("f_resume_req",  32'(imem_req), 32'h1);
        chk("f_resume_addr", imem_addr,     32'h8);
        chk("f_resume_pc",   pc_cur,        32'hC);

        // Three wait cycles: request stable for 4 cycles, one entry pushed
        do_reset(1'b1, 3);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("w_req",  32'(imem_req), 32'h1);
            chk("w_addr", imem_addr,     32'h0);
            chk("w_pc",   pc_cur,        32'h4);
        end
        @(negedge clk);
        chk("w_req0",  32'(imem_req),    32'h0);
        chk("w_valid", 32'(instr_valid), 32'h1);
        chk("w_ipc",   instr_pc,         32'h0);
        @(negedge clk);
        chk("w_empty", 32'(instr_valid), 32'h0);
        chk("w_next",  imem_addr,        32'h4);

        // Branch while waiting: stale word dropped, buffer flushed, refetch at target
        do_reset(1'b0, 0);
        @(negedge clk);
        @(negedge clk); ack_delay = 2;
        @(negedge clk);
        chk("b_pre_req",   32'(imem_req),    32'h1);
        chk("b_pre_valid", 32'(instr_valid), 32'h1);
        branch_taken  = 1'b1;
        branch_target = 32'h100;
        #1;
        chk("b_pcwe", 32'(pc_we), 32'h1);
        chk("b_pcin", pc_in,      32'h100);
        @(negedge clk);
        branch_taken = 1'b0;
        chk("b_flush", 32'(instr_valid), 32'h0);
        chk("b_drop_req",  32'(imem_req), 32'h1);
        chk("b_drop_addr", imem_addr,     32'h4);
        chk("b_pc",        pc_cur,        32'h100);
        @(negedge clk);
        chk("b_drop_v1", 32'(instr_valid), 32'h0);
        @(negedge clk);
        chk("b_drop_v2", 32'(instr_valid), 32'h0);
        chk("b_idle",    32'(imem_req),    32'h0);
        chk("b_pc2",     pc_cur,           32'h100);
        ack_delay = 0;
        @(negedge clk);
        chk("b_tgt_addr", imem_addr, 32'h100);
        chk("b_tgt_pc",   pc_cur,    32'h104);
        @(negedge clk);
        chk("b_tgt_valid", 32'(instr_valid), 32'h1);
        chk("b_tgt_ipc",   instr_pc,         32'h100);
        chk("b_tgt_instr", instr,            32'hC0DE0100);

        // Branch coinciding with ack and pop while one entry is buffered
        do_reset(1'b0, 0);
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("c_pre_addr", imem_addr, 32'h4);
        chk("c_pre_ipc",  instr_pc,  32'h0);
        instr_ready   = 1'b1;
        branch_taken  = 1'b1;
        branch_target = 32'h200;
        #1;
        chk("c_pcin", pc_in, 32'h200);
        @(negedge clk);
        branch_taken = 1'b0;
        chk("c_valid", 32'(instr_valid), 32'h0);
        chk("c_req",   32'(imem_req),    32'h0);
        chk("c_pc",    pc_cur,           32'h200);
        chk("c_instr", instr,            32'h0);
        @(negedge clk);
        chk("c_tgt_addr", imem_addr, 32'h200);
        chk("c_tgt_pc",   pc_cur,    32'h204);

        // Asynchronous reset in the middle of a fetch
        do_reset(1'b0, 0);
        @(negedge clk);
        @(negedge clk); ack_delay = 5;
        @(negedge clk);
        chk("r_pre_req",  32'(imem_req), 32'h1);
        chk("r_pre_pcwe", 32'(pc_we),    32'h1);
        #2;
        reset = 1'b0;
        #1;
        chk("r_req",   32'(imem_req),    32'h0);
        chk("r_valid", 32'(instr_valid), 32'h0);
        chk("r_pcwe",  32'(pc_we),       32'h0);
        chk("r_pcin",  pc_in,            32'h0);
        @(negedge clk);
        reset       = 1'b1;
        ack_delay   = 0;
        instr_ready = 1'b1;
        @(negedge clk);
        chk("r_restart_req",  32'(imem_req), 32'h1);
        chk("r_restart_addr", imem_addr,     32'h0);
        chk("r_restart_pc",   pc_cur,        32'h4);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
